sum_bcd_display: RTL and testbench
==================================

Name: sum_bcd_display

Overview:
Downstream consumer of the 4-bit ripple-carry adder stage. Accepts the adder's 5-bit result {carry-out, sum} through a valid/ready handshake. Converts it to BCD with a multi-cycle shift-and-add-3 (double-dabble) sequencer. Drives active-low seven-segment digits with optional leading-zero blanking, replacing the raw LEDR view of the sum with a decimal readout.

Parameters:
WIDTH, 5, binary input width (adder carry-out plus 4 sum bits)
DIGITS, 2, BCD digits produced; legal only if 10^DIGITS > 2^WIDTH-1
BLANK_LZ, 1, 1 = blank leading zero digits (digit 0 never blanked); 0 = show all digits

Ports:
Clock  input  1  single clock; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a result to convert
in_ready  output  1  block can accept; high only in IDLE
in_data  input  WIDTH  binary value, unsigned
out_valid  output  1  one-cycle pulse: bcd/hex just updated with a new result
bcd  output  4*DIGITS  packed BCD, digit 0 in bits [3:0]
hex  output  7*DIGITS  active-low segments per digit, bit order g..a (bit6=g, bit0=a), digit 0 in bits [6:0]

Behaviour:
- Reset (sampled at Clock edge): state=IDLE, out_valid=0, bcd=0, hex digit0=7'b1000000 ("0"), higher digits 7'b1111111 if BLANK_LZ=1, else "0". in_ready=1 in the first cycle after reset deasserts.
- Reset has priority over all other events. Reset during SHIFT aborts the conversion: no out_valid, outputs return to reset values.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge k, load shift register {BCD=0, bin=in_data}, counter=0, go to SHIFT.
  - SHIFT: in_ready=0. Each cycle, add 3 to every BCD digit >=5, then shift {BCD,bin} left one bit; counter++.
  - After WIDTH shifts (edge k+WIDTH): register bcd and hex from the BCD field, set out_valid=1 for exactly the following cycle, return to IDLE.
- Latency: out_valid high in cycle k+WIDTH+1 when accepted at edge k. Throughput: one conversion per WIDTH+1 cycles. Back-to-back acceptance is allowed in the cycle out_valid is high.
- in_valid while busy is ignored. in_data is captured only at the handshake edge; later changes have no effect.
- bcd/hex hold the last completed result until the next completion.
- Digit arithmetic is 4-bit per digit; the add-3 correction never carries between digits. Non-decimal codes are unreachable. The decoder maps 10-15 to all-off (7'b1111111) defensively.
- Segment codes (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Blanking (BLANK_LZ=1): digit i>0 is blank iff it and all higher digits are 0. bcd is never blanked.
- Combinational hex decode from the registered bcd is permitted. hex must change only in the same cycles bcd changes.

Test Plan:
- Reset held 2 cycles then released -> in_ready=1, out_valid=0, bcd=8'h00, hex[6:0]=1000000, hex[13:7]=1111111.
- in_data=5'd31 (adder 15+15+1) accepted at edge k -> out_valid only in cycle k+6, bcd=8'h31, hex[13:7]=0110000, hex[6:0]=1111001; in_ready=0 during cycles k+1..k+5.
- in_data=0, then 5'd10 -> first: bcd=8'h00, digit1 blank; second: bcd=8'h10, hex[13:7]=1111001, hex[6:0]=1000000. Repeat 10 with BLANK_LZ=0 and 0 with BLANK_LZ=0 -> digit1 shows "0".
- in_valid held high, in_data=9 then changed to 22 mid-conversion -> first result 8'h09 (no corruption). 22 is accepted in the out_valid cycle and yields 8'h22. Exactly two out_valid pulses, 6 cycles apart.
- Reset asserted at cycle k+3 of a conversion of 5'd27 -> no out_valid, bcd=0. Next accepted 5'd27 -> bcd=8'h27.
- Exhaustive sweep 0..31 driven from part3-style A+B+cin combinations -> bcd equals decimal of {cout,S} and hex matches the table for every value.

Source files
------------

// File: rtl/sum_bcd_display.sv
// Binary-to-BCD display stage for the ripple-carry adder result.
// Accepts {carry-out, sum} over a valid/ready handshake, converts it with a
// shift-and-add-3 sequencer (one bit per cycle), then presents packed BCD
// and active-low seven-segment codes with optional leading-zero blanking.
// DIGITS must satisfy 10**DIGITS > 2**WIDTH - 1 so the BCD field cannot overflow.
module sum_bcd_display #(
    parameter int WIDTH    = 5,
    parameter int DIGITS   = 2,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    output logic [4*DIGITS-1:0] bcd,
    output logic [7*DIGITS-1:0] hex
);

    localparam int BW = 4 * DIGITS;              // BCD field width
    localparam int SW = BW + WIDTH;              // {BCD, binary} shift register width
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [SW-1:0]   sr_q, sr_d, sr_adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            out_valid_q, out_valid_d;
    logic            lz_run;

    // Active-low segment code (bit6=g .. bit0=a); 10-15 cannot occur but decode to blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // State register: sequencer state, shift register, counter and result registers.
    always_ff @(posedge Clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: accept in IDLE, then WIDTH add-3/shift steps, then publish the BCD field.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        out_valid_d = 1'b0;

        // Per-digit correction is 4-bit only; a digit >= 5 plus 3 stays below 16.
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_adj[WIDTH+4*i +: 4] >= 4'd5) begin
                sr_adj[WIDTH+4*i +: 4] = sr_adj[WIDTH+4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone is the handshake.
                if (in_valid) begin
                    sr_d    = {{BW{1'b0}}, in_data};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {sr_adj[SW-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    bcd_d       = sr_d[SW-1 -: BW];
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // Outputs: handshake ready, result pulse, and segment decode of the registered BCD.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        bcd       = bcd_q;
        hex       = '1;
        lz_run    = 1'b1;
        // Walk from the most significant digit; a digit is blank while it and all above are 0.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            lz_run = lz_run && (bcd_q[4*i +: 4] == 4'd0);
            if (BLANK_LZ && (i > 0) && lz_run) begin
                hex[7*i +: 7] = 7'b1111111;
            end else begin
                hex[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_sum_bcd_display.sv
// Self-checking bench for sum_bcd_display. Two instances share the stimulus:
// one with leading-zero blanking, one without. Accepted values are queued at
// the handshake edge and compared against a decimal/segment model on out_valid.
module tb_sum_bcd_display;

    localparam int WIDTH  = 5;
    localparam int DIGITS = 2;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;

    logic        in_ready_b, out_valid_b;
    logic [7:0]  bcd_b;
    logic [13:0] hex_b;
    logic        in_ready_n, out_valid_n;
    logic [7:0]  bcd_n;
    logic [13:0] hex_n;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int value;
        int acc_edge;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;

    sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut_b (
        .Clock    (Clock),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready_b),
        .in_data  (in_data),
        .out_valid(out_valid_b),
        .bcd      (bcd_b),
        .hex      (hex_b)
    );

    sum_bcd_display #(.WIDTH(WIDTH), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut_n (
        .Clock    (Clock),
        .Reset    (Reset),
        .in_valid (in_valid),
        .in_ready (in_ready_n),
        .in_data  (in_data),
        .out_valid(out_valid_n),
        .bcd      (bcd_n),
        .hex      (hex_n)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] exp_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [13:0] exp_hex(input int v, input bit blank);
        logic [6:0] hi;
        hi = (blank && (v / 10 == 0)) ? 7'b1111111 : seg_ref(v / 10);
        return {hi, seg_ref(v % 10)};
    endfunction

    // Edge counter: after rising edge e, cyc == e.
    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard push at the handshake edge; reset discards anything in flight.
    always @(posedge Clock) begin
        if (Reset) begin
            sb_q.delete();
        end else if (in_valid && in_ready_b) begin
            sb_q.push_back('{value: int'(in_data), acc_edge: cyc + 1});
        end
    end

    // Scoreboard pop and compare whenever a result is announced.
    always @(negedge Clock) begin
        if (out_valid_b || out_valid_n) begin
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", {30'd0, out_valid_b, out_valid_n}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("ov_b", out_valid_b, 1);
                check("ov_n", out_valid_n, 1);
                check("latency", cyc - e.acc_edge, WIDTH);
                check("bcd_b", bcd_b, exp_bcd(e.value));
                check("hex_b", hex_b, exp_hex(e.value, 1'b1));
                check("bcd_n", bcd_n, exp_bcd(e.value));
                check("hex_n", hex_n, exp_hex(e.value, 1'b0));
            end
        end
    end

    // Present v at a falling edge and return just after the accepting rising edge.
    task automatic send(input logic [WIDTH-1:0] v);
        @(negedge Clock);
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 20 && !in_ready_b; n++) @(negedge Clock);
        check("accept_ready", in_ready_b, 1);
        @(posedge Clock);
    endtask

    // Bounded wait for the result pulse, then step past it.
    task automatic wait_result();
        for (int n = 0; n < 20 && !out_valid_b; n++) @(negedge Clock);
        check("result_seen", out_valid_b, 1);
        @(negedge Clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        int first_cyc;
        int second_cyc;
        bit drop;
        int cin;
        int rem;
        int a;
        int b;

        // Reset held for two edges.
        Reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_ready", in_ready_b, 1);
        check("rst_ov", out_valid_b, 0);
        check("rst_bcd", bcd_b, 8'h00);
        check("rst_hex_b", hex_b, {7'b1111111, 7'b1000000});
        check("rst_hex_n", hex_n, {7'b1000000, 7'b1000000});

        // 31 = 15+15+1: busy window, single pulse, explicit segment codes.
        send(5'd31);
        @(negedge Clock);
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            check("busy_ready", in_ready_b, 0);
            check("busy_ov", out_valid_b, 0);
            if (i < 5) @(negedge Clock);
        end
        @(negedge Clock);
        check("d31_ov", out_valid_b, 1);
        check("d31_ready", in_ready_b, 1);
        check("d31_bcd", bcd_b, 8'h31);
        check("d31_hex_hi", hex_b[13:7], 7'b0110000);
        check("d31_hex_lo", hex_b[6:0], 7'b1111001);
        @(negedge Clock);
        check("d31_pulse_end", out_valid_b, 0);
        check("d31_hold", bcd_b, 8'h31);

        // Zero then ten: blanking on one instance, plain zero digit on the other.
        send(5'd0);
        @(negedge Clock);
        in_valid = 1'b0;
        wait_result();
        check("d0_hex_b", hex_b, {7'b1111111, 7'b1000000});
        check("d0_hex_n", hex_n, {7'b1000000, 7'b1000000});
        send(5'd10);
        @(negedge Clock);
        in_valid = 1'b0;
        wait_result();
        check("d10_bcd", bcd_b, 8'h10);
        check("d10_hex_b", hex_b, {7'b1111001, 7'b1000000});
        check("d10_hex_n", hex_n, {7'b1111001, 7'b1000000});

        // in_valid held; data changes mid-conversion; back-to-back accept in the pulse cycle.
        send(5'd9);
        @(negedge Clock);
        in_data    = 5'd22;
        pulses     = 0;
        first_cyc  = 0;
        second_cyc = 0;
        drop       = 1'b0;
        for (int n = 0; n < 16; n++) begin
            if (drop) in_valid = 1'b0;
            if (out_valid_b) begin
                if (pulses == 0) first_cyc = cyc;
                else second_cyc = cyc;
                pulses++;
                if (pulses == 1) drop = 1'b1;
            end
            @(negedge Clock);
        end
        in_valid = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_spacing", second_cyc - first_cyc, 6);
        check("b2b_bcd", bcd_b, 8'h22);

        // Reset in the middle of converting 27 aborts it.
        send(5'd27);
        @(negedge Clock);
        in_valid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            check("abort_no_ov", out_valid_b, 0);
            @(negedge Clock);
        end
        check("abort_bcd", bcd_b, 8'h00);
        check("abort_hex_b", hex_b, {7'b1111111, 7'b1000000});
        check("abort_hex_n", hex_n, {7'b1000000, 7'b1000000});
        check("abort_ready", in_ready_b, 1);
        send(5'd27);
        @(negedge Clock);
        in_valid = 1'b0;
        wait_result();
        check("d27_bcd", bcd_b, 8'h27);

        // Sweep every adder result A+B+cin from 0 to 31.
        for (int v = 0; v < 32; v++) begin
            cin = v % 2;
            rem = v - cin;
            a   = rem / 2;
            b   = rem - a;
            send(5'(a + b + cin));
            @(negedge Clock);
            in_valid = 1'b0;
            wait_result();
        end

        check("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
